lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Datapath and memory-side signals of the load/store controller, bundled into one interface.
// The controller connects through the slave modport; the datapath/memory model uses master.
interface lsu_ctrl_if;
    logic        re;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  re, we, funct3, addr, wdata, mem_ack, mem_rdata,
        output stall, done, err, load_data,
        output mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output re, we, funct3, addr, wdata, mem_ack, mem_rdata,
        input  stall, done, err, load_data,
        input  mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: validates a datapath access, runs one word-wide memory
// transaction with a timeout, and returns extended load data with a done/err pulse.
//
// state | meaning
// IDLE  | waiting for re/we; illegal requests are rejected here with a comb err pulse
// BUSY  | mem_req held, waiting for mem_ack or the timeout
// RESP  | one-cycle done pulse (err if timed out), then back to IDLE
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus_io
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_flag_q, err_flag_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;

    logic        is_load, is_store, legal_f3, misaligned, accept, reject;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        is_load  = bus_io.re & ~bus_io.we;
        is_store = bus_io.we & ~bus_io.re;
        legal_f3 = 1'b0;
        if (is_load) begin
            legal_f3 = (bus_io.funct3 == 3'b000) || (bus_io.funct3 == 3'b001) ||
                       (bus_io.funct3 == 3'b010) || (bus_io.funct3 == 3'b100) ||
                       (bus_io.funct3 == 3'b101);
        end else if (is_store) begin
            legal_f3 = (bus_io.funct3 == 3'b000) || (bus_io.funct3 == 3'b001) ||
                       (bus_io.funct3 == 3'b010);
        end
        misaligned = ((bus_io.funct3[1:0] == 2'b10) && (bus_io.addr[1:0] != 2'b00)) ||
                     ((bus_io.funct3[1:0] == 2'b01) && bus_io.addr[0]);
        accept = (state_q == IDLE) && legal_f3 && !misaligned;
        reject = (state_q == IDLE) && (bus_io.re | bus_io.we) && !accept;
    end

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = bus_io.wdata;
        case (bus_io.funct3[1:0])
            2'b00: begin
                lane_strb  = 4'b0001 << bus_io.addr[1:0];
                lane_wdata = {4{bus_io.wdata[7:0]}};
            end
            2'b01: begin
                lane_strb  = 4'b0011 << {bus_io.addr[1], 1'b0};
                lane_wdata = {2{bus_io.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the offset/size latched at issue, not the live datapath inputs.
    always_comb begin
        rd_shift = bus_io.mem_rdata >> {off_q, 3'b000};
        rd_byte  = rd_shift[7:0];
        rd_half  = off_q[1] ? bus_io.mem_rdata[31:16] : bus_io.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = bus_io.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_flag_d  = err_flag_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = BUSY;
                    cnt_d       = 8'd0;
                    err_flag_d  = 1'b0;
                    f3_d        = bus_io.funct3;
                    off_d       = bus_io.addr[1:0];
                    mem_wr_d    = is_store;
                    mem_addr_d  = {bus_io.addr[31:2], 2'b00};
                    mem_wstrb_d = is_store ? lane_strb : 4'b0000;
                    mem_wdata_d = lane_wdata;
                end
            end
            BUSY: begin
                if (bus_io.mem_ack) begin
                    state_d = RESP;
                    cnt_d   = 8'd0;
                    if (!mem_wr_q) load_data_d = load_ext;
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = RESP;
                    cnt_d       = 8'd0;
                    err_flag_d  = 1'b1;
                    load_data_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            err_flag_q  <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_flag_q  <= err_flag_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus_io.mem_req   = (state_q == BUSY);
    assign bus_io.stall     = accept || (state_q == BUSY);
    assign bus_io.done      = (state_q == RESP);
    assign bus_io.err       = reject || ((state_q == RESP) && err_flag_q);
    assign bus_io.load_data = load_data_q;
    assign bus_io.mem_wr    = mem_wr_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.mem_wstrb = mem_wstrb_q;
    assign bus_io.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset-mid-access sequence, and random
// accesses checked against an arithmetic model of the access rules.
module tb_lsu_ctrl;
    localparam int TMO = 15;

    logic clk;
    logic rst_n;
    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;   // BUSY cycle carrying mem_ack; 0 = never
        logic        rej;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic        tmo;
        logic [31:0] ld;       // load_data expected after the access
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] ld_model = 32'd0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                input int ack, input logic rej, input logic [3:0] strb,
                                input logic [31:0] mwd, input logic tmo, input logic [31:0] ld);
        vec_t v;
        v.re = r; v.we = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.ack_at = ack; v.rej = rej; v.strb = strb; v.mwdata = mwd; v.tmo = tmo; v.ld = ld;
        return v;
    endfunction

    // Reference: derive the expected outcome from access size, offset and signedness.
    function automatic vec_t model(input vec_t vin, input logic [31:0] prev_ld);
        vec_t v = vin;
        int sz = 1 << int'(v.f3[1:0]);
        int off = int'(v.addr[1:0]);
        bit legal;
        longint mask = (longint'(1) << (8 * sz)) - 1;
        longint val;
        longint res = 0;
        if (v.re && !v.we) legal = (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        else if (v.we && !v.re) legal = (v.f3 inside {3'd0, 3'd1, 3'd2});
        else legal = 0;
        v.rej = !legal || (off % sz != 0);
        v.tmo = (v.ack_at == 0) || (v.ack_at > TMO);
        v.strb = 4'(((1 << sz) - 1) << off);
        if (!v.rej) begin
            for (int k = 0; k < 4 / sz; k++) res = res | ((longint'(v.wdata) & mask) << (8 * sz * k));
        end
        v.mwdata = 32'(res);
        val = (longint'(v.rdata) >> (8 * off)) & mask;
        if (!v.f3[2] && sz < 4 && val >= (longint'(1) << (8 * sz - 1))) val = val - (longint'(1) << (8 * sz));
        if (v.rej) v.ld = prev_ld;
        else if (v.tmo) v.ld = 32'd0;
        else if (v.re) v.ld = 32'(val);
        else v.ld = prev_ld;
        return v;
    endfunction

    // Starts at posedge+1 with the controller in IDLE; ends at posedge+1 back in IDLE.
    task automatic run_access(input vec_t v, input string tag);
        int busy = 0;
        int exp_busy;
        logic [31:0] exp_addr = {v.addr[31:2], 2'b00};
        bus.re = v.re; bus.we = v.we; bus.funct3 = v.f3; bus.addr = v.addr; bus.wdata = v.wdata;
        #1;
        if (v.rej) begin
            chk({tag, " rej err"}, 32'(bus.err), 32'd1);
            chk({tag, " rej stall"}, 32'(bus.stall), 32'd0);
            @(posedge clk); #1;
            bus.re = 1'b0; bus.we = 1'b0;
            #1;
            chk({tag, " rej no mem_req/done/err"}, {29'd0, bus.mem_req, bus.done, bus.err}, 32'd0);
            chk({tag, " rej load_data"}, bus.load_data, v.ld);
            return;
        end
        chk({tag, " issue stall/err"}, {30'd0, bus.stall, bus.err}, 32'd2);
        @(posedge clk); #1;
        bus.re = 1'b0; bus.we = 1'b0;
        bus.addr = $urandom; bus.wdata = $urandom;
        exp_busy = v.tmo ? TMO : v.ack_at;
        while (bus.mem_req && busy < 300) begin
            busy++;
            chk({tag, " busy stall"}, 32'(bus.stall), 32'd1);
            chk({tag, " mem_addr"}, bus.mem_addr, exp_addr);
            chk({tag, " mem_wr/wstrb"}, {27'd0, bus.mem_wr, bus.mem_wstrb}, {27'd0, v.we, v.we ? v.strb : 4'b0000});
            if (v.we) chk({tag, " mem_wdata"}, bus.mem_wdata, v.mwdata);
            bus.mem_rdata = (busy == v.ack_at) ? v.rdata : $urandom;
            bus.mem_ack = (busy == v.ack_at);
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
        end
        chk({tag, " busy cycles"}, 32'(busy), 32'(exp_busy));
        chk({tag, " resp done/err/stall"}, {29'd0, bus.done, bus.err, bus.stall}, {29'd0, 1'b1, v.tmo, 1'b0});
        chk({tag, " load_data"}, bus.load_data, v.ld);
        @(posedge clk); #1;
        chk({tag, " done pulse ends"}, {30'd0, bus.done, bus.err}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.re = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

        //           re we f3    addr          wdata          rdata          ack rej strb     mwdata        tmo ld
        tbl.push_back(mk(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_7F01, 2,  0, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(0, 1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'h0,         1,  0, 4'b1100, 32'hABCD_ABCD, 0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0006, 32'h0,         32'h0,         1,  1, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 1, 3'b010, 32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(0, 1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         1,  1, 4'b0000, 32'h0,         0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 1,  0, 4'b0000, 32'h0,         0, 32'hDEAD_BEEF));
        tbl.push_back(mk(1, 0, 3'b101, 32'h0000_0012, 32'h0,         32'h8001_0000, 3,  0, 4'b0000, 32'h0,         0, 32'h0000_8001));
        tbl.push_back(mk(1, 0, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_0000, 2,  0, 4'b0000, 32'h0,         0, 32'hFFFF_8001));
        tbl.push_back(mk(1, 0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_A500, 1,  0, 4'b0000, 32'h0,         0, 32'h0000_00A5));
        tbl.push_back(mk(0, 1, 3'b000, 32'h0000_0003, 32'h7777_77EE, 32'h0,         1,  0, 4'b1000, 32'hEEEE_EEEE, 0, 32'h0000_00A5));
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         4,  0, 4'b1111, 32'hCAFE_F00D, 0, 32'h0000_00A5));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0008, 32'h0,         32'h0,         0,  0, 4'b0000, 32'h0,         1, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_000C, 32'h0,         32'h0123_4567, 15, 0, 4'b0000, 32'h0,         0, 32'h0123_4567));
        tbl.push_back(mk(1, 0, 3'b000, 32'h0000_0001, 32'h0,         32'h0000_7F00, 1,  0, 4'b0000, 32'h0,         0, 32'h0000_007F));
        tbl.push_back(mk(0, 1, 3'b001, 32'h0000_0000, 32'h0000_BEEF, 32'h0,         1,  0, 4'b0011, 32'hBEEF_BEEF, 0, 32'h0000_007F));
        tbl.push_back(mk(0, 1, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0,         2,  0, 4'b0010, 32'hABAB_ABAB, 0, 32'h0000_007F));
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_0044, 32'h0000_0001, 32'h0,         0,  0, 4'b1111, 32'h0000_0001, 1, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0000, 32'h0,         32'h55AA_55AA, 1,  0, 4'b0000, 32'h0,         0, 32'h55AA_55AA));

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {26'd0, bus.stall, bus.done, bus.err, bus.mem_req, bus.mem_wr, 1'b0}, 32'd0);
        chk("reset load_data", bus.load_data, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_access(tbl[i], $sformatf("vec%0d", i));
            ld_model = tbl[i].ld;
        end

        // Reset during the second BUSY cycle of a store, then a load in the first IDLE cycle.
        bus.re = 1'b0; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0000_0080; bus.wdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus.we = 1'b0;
        chk("rst seq busy1 mem_req", 32'(bus.mem_req), 32'd1);
        @(posedge clk); #1;
        chk("rst seq busy2 mem_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst seq mem_req/stall/wr", {29'd0, bus.mem_req, bus.stall, bus.mem_wr}, 32'd0);
        chk("rst seq wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst seq mem_addr", bus.mem_addr, 32'd0);
        chk("rst seq mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst seq load_data", bus.load_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_access(mk(1, 0, 3'b101, 32'h0000_0012, 32'h0, 32'h8001_0000, 1, 0, 4'b0000, 32'h0, 0, 32'h0000_8001), "post-reset lhu");
        ld_model = 32'h0000_8001;

        for (int i = 0; i < 200; i++) begin
            vec_t v;
            int pick = $urandom_range(0, 9);
            v.re = (pick < 5) || (pick == 9);
            v.we = (pick >= 5);
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
            v = model(v, ld_model);
            run_access(v, $sformatf("rnd%0d", i));
            ld_model = v.ld;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
